// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl -- read-side controller of an asynchronous FIFO.
//
// Keeps the binary/Gray read pointers and the registered empty flag. A
// one-word output register presents data with a valid/ready handshake, so
// the storage array sees a single combinational read port at raddr.
//
// Optional feature: define RD_ALMOST_EMPTY_EN to build the almost-empty
// flag. It converts the synchronized write pointer back to binary and
// compares the array occupancy against AE_LEVEL. When the macro is not
// defined, ralmost_empty is tied low and none of that logic is built.

module fifo_rd_ctrl #(
    parameter int ASIZE    = 4,
    parameter int DSIZE    = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr_sync,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             rd_valid,
    output logic [DSIZE-1:0] rd_data,
    input  logic             rd_ready,
    output logic             ralmost_empty
);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rgray;
    logic [ASIZE:0] rbin_next;
    logic [ASIZE:0] rgray_next;
    logic           pop;

    // A word leaves the array whenever it holds data and the output register
    // is free, or is being emptied by the consumer in this same cycle. Because
    // rempty gates the pop, an underflow cannot be issued.
    assign pop = ~rempty & (~rd_valid | rd_ready);

    assign rbin_next  = rbin + {{ASIZE{1'b0}}, pop};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    assign raddr = rbin[ASIZE-1:0];
    assign rptr  = rgray;

    // Read pointers: binary for addressing, Gray for the write-domain crossing.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin  <= '0;
            rgray <= '0;
        end else begin
            // NOTE: registers are updated with <= so every block samples the
            // pre-edge values; blocking assignments here would create races.
            rbin  <= rbin_next;
            rgray <= rgray_next;
        end
    end

    // Empty flag compares the post-pop Gray pointer against the write
    // pointer, so a pop and a write-pointer move in one cycle both count.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rempty <= 1'b1;
        end else begin
            rempty <= (rgray_next == wptr_sync);
        end
    end

    // Output register: load on pop, drop valid once the consumer takes it.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            // NOTE: the data register is reset as well, so a word caught
            // mid-transfer can never reappear after reset.
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (pop) begin
            rd_valid <= 1'b1;
            rd_data  <= mem_rdata;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

`ifdef RD_ALMOST_EMPTY_EN
    localparam logic [ASIZE:0] AE_LVL = AE_LEVEL[ASIZE:0];

    logic [ASIZE:0] wbin_conv;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] level;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_conv = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            wbin_conv[i] = ^(wptr_sync >> i);
        end
    end

    // Registered binary write pointer breaks the path from the synchronizer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wbin <= '0;
        end else begin
            wbin <= wbin_conv;
        end
    end

    // Occupancy of the array (modulo arithmetic handles pointer wrap).
    assign level = wbin - rbin_next;

    // Almost-empty flag, registered so downstream sees a clean level.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            ralmost_empty <= 1'b1;
        end else begin
            ralmost_empty <= (level <= AE_LVL);
        end
    end
`else
    assign ralmost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl -- self-checking bench for fifo_rd_ctrl (ASIZE=4, DSIZE=8,
// AE_LEVEL=2). A directed vector table covers reset, latency, hold and
// simultaneous pop/write cases; hand-written sequences cover async reset,
// a 40-word wrapping stream and a 100-word random-backpressure run.

module tb_fifo_rd_ctrl;

    localparam int ASIZE = 4;
    localparam int DSIZE = 8;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic [ASIZE:0]   wptr_sync;
    logic [DSIZE-1:0] mem_rdata;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic             rd_valid;
    logic [DSIZE-1:0] rd_data;
    logic             rd_ready;
    logic             ralmost_empty;

    fifo_rd_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AE_LEVEL(2)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .wptr_sync     (wptr_sync),
        .mem_rdata     (mem_rdata),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .ralmost_empty (ralmost_empty)
    );

    always #5 rclk = ~rclk;

    // Storage array model: in table mode the vector supplies mem_rdata.
    bit               table_mode;
    logic [DSIZE-1:0] vec_data;
    logic [DSIZE-1:0] mem [16];
    assign mem_rdata = table_mode ? vec_data : mem[raddr];

`ifdef RD_ALMOST_EMPTY_EN
    localparam logic AE_RESET = 1'b1;
`else
    localparam logic AE_RESET = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ASIZE:0] gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ASIZE:0] g2b(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b = '0;
        for (int i = 0; i <= ASIZE; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Directed vectors: inputs for one cycle and expected outputs after the edge.
    typedef struct {
        logic [ASIZE:0]   wptr;
        logic [DSIZE-1:0] mdata;
        logic             rdy;
        logic             e_empty;
        logic             e_valid;
        logic [DSIZE-1:0] e_data;
        logic [ASIZE:0]   e_rptr;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic set_vec(input int i, input logic [ASIZE:0] w, input logic [DSIZE-1:0] d,
                           input logic r, input logic ee, input logic ev,
                           input logic [DSIZE-1:0] ed, input logic [ASIZE:0] er);
        vecs[i].wptr = w;  vecs[i].mdata = d;   vecs[i].rdy = r;
        vecs[i].e_empty = ee; vecs[i].e_valid = ev; vecs[i].e_data = ed; vecs[i].e_rptr = er;
    endtask

    // Streaming-phase state: bench acts as the write side.
    logic [ASIZE:0]   wbin_tb;
    int               written;
    int               target;
    int               accepted;
    int               cyc;
    int               first_acc;
    int               last_acc;
    bit               prev_hold;
    logic [DSIZE-1:0] prev_data;
    logic [DSIZE-1:0] exp_q [$];

    // One streaming cycle: drive at negedge, check the handshake before the edge.
    task automatic cycle(input bit rdy, input bit wr_en);
        logic [ASIZE:0]   occ;
        logic [DSIZE-1:0] w;
        @(negedge rclk);
        cyc++;
        if (prev_hold) begin
            check("hold_valid", {31'b0, rd_valid}, 32'd1);
            check("hold_data", {24'b0, rd_data}, {24'b0, prev_data});
        end
        rd_ready = rdy;
        occ = wbin_tb - g2b(rptr);
        if (wr_en && written < target && occ < 5'd16) begin
            w = DSIZE'($urandom);
            mem[wbin_tb[ASIZE-1:0]] = w;
            exp_q.push_back(w);
            wbin_tb   = wbin_tb + 5'd1;
            wptr_sync = gray(wbin_tb);
            written++;
        end
        #1;
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'd1, 32'd0);
            end else begin
                check("order", {24'b0, rd_data}, {24'b0, exp_q[0]});
                void'(exp_q.pop_front());
            end
            accepted++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        prev_hold = rd_valid && !rd_ready;
        prev_data = rd_data;
`ifndef RD_ALMOST_EMPTY_EN
        check("ae_tied_low", {31'b0, ralmost_empty}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;

        // Vector table: 10 idle cycles after reset, then latency/hold/pop cases.
        for (int i = 0; i < 10; i++) set_vec(i, 5'd0, 8'h00, i[0], 1, 0, 8'h00, 5'd0);
        set_vec(10, 5'd1, 8'hA5, 0, 0, 0, 8'h00, 5'd0);  // wptr moves: rempty falls
        set_vec(11, 5'd1, 8'hA5, 0, 1, 1, 8'hA5, 5'd1);  // first pop, empty again
        set_vec(12, 5'd1, 8'h5A, 0, 1, 1, 8'hA5, 5'd1);  // stalled: hold
        set_vec(13, 5'd1, 8'h5A, 1, 1, 0, 8'hA5, 5'd1);  // taken, nothing to pop
        set_vec(14, 5'd2, 8'h11, 1, 0, 0, 8'hA5, 5'd1);  // two more words written
        set_vec(15, 5'd2, 8'h11, 1, 0, 1, 8'h11, 5'd3);
        set_vec(16, 5'd2, 8'h22, 0, 0, 1, 8'h11, 5'd3);  // backpressure blocks pop
        set_vec(17, 5'd2, 8'h22, 1, 1, 1, 8'h22, 5'd2);
        set_vec(18, 5'd2, 8'h33, 1, 1, 0, 8'h22, 5'd2);
        set_vec(19, 5'd6, 8'h44, 1, 0, 0, 8'h22, 5'd2);
        set_vec(20, 5'd7, 8'h44, 1, 0, 1, 8'h44, 5'd6);  // pop and wptr move together
        set_vec(21, 5'd7, 8'h55, 1, 1, 1, 8'h55, 5'd7);
        set_vec(22, 5'd7, 8'h55, 1, 1, 0, 8'h55, 5'd7);

        table_mode = 1'b1;
        vec_data   = 8'h00;
        wptr_sync  = '0;
        rd_ready   = 1'b0;
        rrst_n     = 1'b0;
        prev_hold  = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        #12;
        check("rst_empty", {31'b0, rempty}, 32'd1);
        check("rst_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_rptr", {27'b0, rptr}, 32'd0);
        check("rst_ae", {31'b0, ralmost_empty}, {31'b0, AE_RESET});
        @(negedge rclk);
        rrst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge rclk);
            wptr_sync = vecs[i].wptr;
            vec_data  = vecs[i].mdata;
            rd_ready  = vecs[i].rdy;
            @(posedge rclk);
            #1;
            check($sformatf("v%0d_empty", i), {31'b0, rempty}, {31'b0, vecs[i].e_empty});
            check($sformatf("v%0d_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_data", i), {24'b0, rd_data}, {24'b0, vecs[i].e_data});
            check($sformatf("v%0d_rptr", i), {27'b0, rptr}, {27'b0, vecs[i].e_rptr});
`ifndef RD_ALMOST_EMPTY_EN
            check($sformatf("v%0d_ae", i), {31'b0, ralmost_empty}, 32'd0);
`endif
        end

        // Drive rbin to 7 with a word held, then reset asynchronously mid-cycle.
        @(negedge rclk);
        wptr_sync = gray(5'd7);
        vec_data  = 8'h66;
        rd_ready  = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
        check("pre_rst_rptr", {27'b0, rptr}, {27'b0, gray(5'd7)});
        check("pre_rst_raddr", {28'b0, raddr}, 32'd7);
        check("pre_rst_valid", {31'b0, rd_valid}, 32'd1);
        @(negedge rclk);
        rd_ready = 1'b0;
        #2;
        rrst_n = 1'b0;
        #1;
        check("async_rst_empty", {31'b0, rempty}, 32'd1);
        check("async_rst_valid", {31'b0, rd_valid}, 32'd0);
        check("async_rst_data", {24'b0, rd_data}, 32'd0);
        check("async_rst_rptr", {27'b0, rptr}, 32'd0);
        check("async_rst_raddr", {28'b0, raddr}, 32'd0);
        check("async_rst_ae", {31'b0, ralmost_empty}, {31'b0, AE_RESET});

        // Streaming phase: 40 words with rd_ready held high.
        table_mode = 1'b0;
        wptr_sync  = '0;
        wbin_tb    = '0;
        written    = 0;
        target     = 40;
        accepted   = 0;
        cyc        = 0;
        first_acc  = -1;
        last_acc   = -1;
        prev_hold  = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;

        budget = 0;
        while (accepted < 40 && budget < 200) begin
            cycle(1'b1, 1'b1);
            budget++;
        end
        check("stream_count", accepted, 32'd40);
        check("stream_one_per_cycle", last_acc - first_acc, 32'd39);
        cycle(1'b1, 1'b0);
        check("stream_wrap_rptr", {27'b0, rptr}, {27'b0, gray(5'd8)});
        check("stream_drained", {31'b0, rd_valid}, 32'd0);

        // Random backpressure and random write gaps over 100 more words.
        target = 140;
        budget = 0;
        while (accepted < 140 && budget < 3000) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            budget++;
        end
        check("random_count", accepted, 32'd140);
        repeat (4) cycle(1'b1, 1'b0);
        check("random_queue_empty", exp_q.size(), 32'd0);
        check("random_rempty", {31'b0, rempty}, 32'd1);

`ifdef RD_ALMOST_EMPTY_EN
        repeat (3) cycle(1'b0, 1'b0);
        check("ae_level0", {31'b0, ralmost_empty}, 32'd1);
        target = 144;
        repeat (4) cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        check("ae_level3", {31'b0, ralmost_empty}, 32'd0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("ae_level2", {31'b0, ralmost_empty}, 32'd1);
        repeat (6) cycle(1'b1, 1'b0);
        check("ae_drained", {31'b0, ralmost_empty}, 32'd1);
        check("ae_all_words", accepted, 32'd144);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
